debounce_sync: RTL

DEBOUNCE_SYNC -- requirements
Module: debounce_sync

---
 rtl/debounce_sync.sv | 78 +++++++
 1 files changed

// File: rtl/debounce_sync.sv
// Synchronizes an asynchronous level and accepts a new value only after it has
// been stable for DEBOUNCE_CYCLES clocks; emits one-cycle rise/fall pulses.
module debounce_sync #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_WIDTH       = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic din_async,
  input  logic clear,
  output logic dout,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam logic [CNT_WIDTH-1:0] LP_CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_WIDTH-1:0]   r_cnt;
  logic                   r_dout;
  logic                   r_rise;
  logic                   r_fall;
  logic                   r_busy;

  logic                   w_sync_out;
  logic                   w_mismatch;
  logic                   w_done;
  logic                   w_accept;
  logic [CNT_WIDTH-1:0]   w_cnt_nxt;

  assign w_sync_out = r_sync[SYNC_STAGES-1];
  assign w_mismatch = (w_sync_out != r_dout);
  assign w_done     = w_mismatch && (r_cnt == LP_CNT_LAST);
  // clear outranks a completing count: the level is not accepted that cycle
  assign w_accept   = w_done && !clear;

  always_comb begin
    w_cnt_nxt = '0;
    if (!clear && w_mismatch && !w_done) begin
      w_cnt_nxt = r_cnt + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], din_async};
    end
  end

  // busy is registered from the next count so it always equals (r_cnt != 0)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_dout <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      r_busy <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_busy <= (w_cnt_nxt != '0);
      r_rise <= w_accept && w_sync_out;
      r_fall <= w_accept && !w_sync_out;
      if (w_accept) begin
        r_dout <= w_sync_out;
      end
    end
  end

  assign dout = r_dout;
  assign rise = r_rise;
  assign fall = r_fall;
  assign busy = r_busy;

endmodule
